video_timing: RTL and testbench
===============================

VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 SHALL have parameter H_TOTAL, default 320, meaning pixel clocks per line.
REQ-002 SHALL have parameter H_VISIBLE, default 256, meaning active pixels per line.
REQ-003 SHALL have parameters HS_START and HS_END, defaults 272 and 304, meaning hsync_n low for hcount in [HS_START, HS_END).
REQ-004 SHALL have parameter V_TOTAL, default 256, meaning lines per frame.
REQ-005 SHALL have parameter V_VISIBLE, default 232, meaning active lines per frame.
REQ-006 SHALL have parameters VS_START and VS_END, defaults 240 and 244, meaning vsync_n low for vcount in [VS_START, VS_END).
REQ-007 SHALL have port: clk  input  1  10 MHz system clock; the only clock.
REQ-008 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port: ce5  input  1  5 MHz pixel clock enable, one clk wide.
REQ-010 SHALL have port: irq_ack  input  1  single-cycle CPU interrupt acknowledge.
REQ-011 SHALL have port: hcount  output  9  horizontal pixel counter.
REQ-012 SHALL have port: vcount  output  8  vertical line counter.
REQ-013 SHALL have ports: hblank, vblank  output  1 each  blanking, active-high.
REQ-014 SHALL have ports: hsync_n, vsync_n  output  1 each  sync, active-low.
REQ-015 SHALL have port: frame_start  output  1  one-clk pulse at the first pixel of a frame.
REQ-016 SHALL have port: irq  output  1  level CPU interrupt request.

Function
REQ-017 hcount SHALL advance only on clk edges with ce5=1; with ce5=0, all state SHALL hold.
REQ-018 At hcount=H_TOTAL-1 with ce5=1, hcount SHALL wrap to 0 and vcount SHALL increment.
REQ-019 At vcount=V_TOTAL-1 at a line wrap, vcount SHALL wrap to 0.
REQ-020 hblank SHALL be 1 iff hcount>=H_VISIBLE; vblank SHALL be 1 iff vcount>=V_VISIBLE.
REQ-021 hsync_n and vsync_n SHALL decode per REQ-003/REQ-006.
REQ-022 Decodes in REQ-020/021 SHALL be combinational from the registered counters, with zero latency relative to hcount/vcount.
REQ-023 frame_start SHALL be 1 for exactly the one clk in which hcount=0, vcount=0 and ce5=1.
REQ-024 irq SHALL set on the clk edge after a cycle with ce5=1, hcount=0 and vcount[5:0]=0, i.e. at lines 0, 64, 128 and 192.
REQ-025 irq SHALL stay set until sampled irq_ack=1, then clear on that edge.
REQ-026 irq_ack and a set condition in the same cycle: set SHALL win and irq SHALL stay 1.
REQ-027 irq_ack while irq=0 SHALL have no effect.
REQ-028 Arithmetic SHALL be unsigned; counter widths SHALL be fixed at 9 and 8 bits; parameters SHALL satisfy VISIBLE<SYNC_START<SYNC_END<=TOTAL.
REQ-029 Parameter violations SHALL fail elaboration.

Reset
REQ-030 On reset=1 at a clk edge, the following SHALL apply regardless of ce5 or irq_ack: hcount=0, vcount=0, irq=0.
REQ-031 Consequently, during and directly after reset: hblank=0, vblank=0, hsync_n=1, vsync_n=1.
REQ-032 frame_start SHALL be 0 while reset=1.
REQ-033 Reset asserted mid-line or mid-frame SHALL restart timing at pixel 0 of line 0 on the next enabled cycle, with no partial sync pulse retained.

Structure
REQ-034 Default timing constants and the counter widths (9, 8) SHALL live in a shared video timing package, which the object and sprite stages also use.
REQ-035 One sub-module is natural: video_irq, holding the set/ack flip-flop of REQ-024..027.
REQ-036 All logic SHALL be synchronous to clk; no derived clocks.

Verification
REQ-037 ce5 toggling every other clk from reset -> hcount 0..319 then 0; vcount increments from 0 to 1 at the wrap; 640 clk per line.
REQ-038 Full frame -> hblank high for hcount 256..319; hsync_n low exactly for hcount 272..303; vblank high for vcount 232..255; vsync_n low for 240..243; frame_start high once per 163840 clk.
REQ-039 No irq_ack -> irq rises after line 0, hcount 0, and stays high through line 64.
REQ-040 irq_ack pulsed at vcount 10 -> irq low from the next edge until line 64, hcount 0.
REQ-041 irq_ack asserted in the exact set cycle at line 128 -> irq remains 1.
REQ-042 reset pulsed at hcount=280 (hsync_n low), vcount=100, ce5 held 1 -> next cycle hcount=0, vcount=0, hsync_n=1, irq=0.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared video timing definitions: default CRT timing constants and the fixed
// counter widths used by the timing generator and the object/sprite stages.
package video_timing_pkg;

    localparam int unsigned HCountWidth = 9;
    localparam int unsigned VCountWidth = 8;

    localparam int unsigned DefHTotal   = 320;
    localparam int unsigned DefHVisible = 256;
    localparam int unsigned DefHsStart  = 272;
    localparam int unsigned DefHsEnd    = 304;

    localparam int unsigned DefVTotal   = 256;
    localparam int unsigned DefVVisible = 232;
    localparam int unsigned DefVsStart  = 240;
    localparam int unsigned DefVsEnd    = 244;

    typedef logic [HCountWidth-1:0] hcount_t;
    typedef logic [VCountWidth-1:0] vcount_t;

endpackage

// File: rtl/video_timing_if.sv
// Video timing bus: pixel enable and CPU interrupt acknowledge towards the
// timing generator, counters/blanking/sync/frame/irq back to the consumers.
//   master : timing generator side (drives counters, decodes, irq)
//   slave  : consumer / CPU side (drives ce5, irq_ack)
interface video_timing_if;
    import video_timing_pkg::*;

    logic    ce5;
    logic    irq_ack;
    hcount_t hcount;
    vcount_t vcount;
    logic    hblank;
    logic    vblank;
    logic    hsync_n;
    logic    vsync_n;
    logic    frame_start;
    logic    irq;

    modport master (
        input  ce5, irq_ack,
        output hcount, vcount, hblank, vblank, hsync_n, vsync_n, frame_start, irq
    );

    modport slave (
        output ce5, irq_ack,
        input  hcount, vcount, hblank, vblank, hsync_n, vsync_n, frame_start, irq
    );

endinterface

// File: rtl/video_irq.sv
// Level CPU interrupt flip-flop.
//   clk   : system clock
//   reset : synchronous active-high reset, clears irq
//   set   : set request (takes priority over ack)
//   ack   : single-cycle acknowledge, clears irq
//   irq   : registered interrupt request level
module video_irq (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic ack,
    output logic irq
);

    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (set) begin
            irq_d = 1'b1;
        end else if (ack) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: rtl/video_timing.sv
// Video timing generator: pixel/line counters advanced by a pixel clock enable,
// zero-latency blanking/sync decodes, frame start pulse and a CPU interrupt
// raised every 64 lines.
//   clk   : 10 MHz system clock, the only clock
//   reset : synchronous active-high reset
//   bus   : video_timing_if master (ce5, irq_ack in; counters, decodes, irq out)
module video_timing
    import video_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL   = DefHTotal,
    parameter int unsigned H_VISIBLE = DefHVisible,
    parameter int unsigned HS_START  = DefHsStart,
    parameter int unsigned HS_END    = DefHsEnd,
    parameter int unsigned V_TOTAL   = DefVTotal,
    parameter int unsigned V_VISIBLE = DefVVisible,
    parameter int unsigned VS_START  = DefVsStart,
    parameter int unsigned VS_END    = DefVsEnd
) (
    input logic           clk,
    input logic           reset,
    video_timing_if.master bus
);

    if (!(H_VISIBLE < HS_START && HS_START < HS_END && HS_END <= H_TOTAL &&
          H_TOTAL <= (1 << HCountWidth))) begin : g_bad_h_params
        $error("video_timing: illegal horizontal timing parameters");
    end

    if (!(V_VISIBLE < VS_START && VS_START < VS_END && VS_END <= V_TOTAL &&
          V_TOTAL <= (1 << VCountWidth))) begin : g_bad_v_params
        $error("video_timing: illegal vertical timing parameters");
    end

    localparam hcount_t HLast    = hcount_t'(H_TOTAL - 1);
    localparam hcount_t HVisible = hcount_t'(H_VISIBLE);
    localparam hcount_t HsStart  = hcount_t'(HS_START);
    localparam hcount_t HsEnd    = hcount_t'(HS_END);
    localparam vcount_t VLast    = vcount_t'(V_TOTAL - 1);
    localparam vcount_t VVisible = vcount_t'(V_VISIBLE);
    localparam vcount_t VsStart  = vcount_t'(VS_START);
    localparam vcount_t VsEnd    = vcount_t'(VS_END);

    hcount_t hcount_q, hcount_d;
    vcount_t vcount_q, vcount_d;
    logic    at_origin;
    logic    irq_set;

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (bus.ce5) begin
            if (hcount_q == HLast) begin
                hcount_d = '0;
                vcount_d = (vcount_q == VLast) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign bus.hcount  = hcount_q;
    assign bus.vcount  = vcount_q;
    assign bus.hblank  = (hcount_q >= HVisible);
    assign bus.vblank  = (vcount_q >= VVisible);
    assign bus.hsync_n = !((hcount_q >= HsStart) && (hcount_q < HsEnd));
    assign bus.vsync_n = !((vcount_q >= VsStart) && (vcount_q < VsEnd));

    assign at_origin       = (hcount_q == '0) && (vcount_q == '0);
    assign bus.frame_start = bus.ce5 && !reset && at_origin;

    // Interrupt on the first pixel of every 64th line (0, 64, 128, 192).
    assign irq_set = bus.ce5 && (hcount_q == '0) && (vcount_q[5:0] == 6'd0);

    video_irq u_irq (
        .clk   (clk),
        .reset (reset),
        .set   (irq_set),
        .ack   (bus.irq_ack),
        .irq   (bus.irq)
    );

endmodule

// File: tb/tb_video_timing.sv
module tb_video_timing;

    logic clk = 1'b0;
    logic reset = 1'b1;

    video_timing_if bus ();

    video_timing dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #50 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference state: counters and irq after the most recent clock edge.
    int   mh;
    int   mv;
    logic mirq;

    logic [22:0] obs;
    assign obs = {bus.hcount, bus.vcount, bus.hblank, bus.vblank, bus.hsync_n, bus.vsync_n,
                  bus.frame_start, bus.irq};

    // Apply inputs half a cycle before the edge and let the decodes settle.
    task automatic drive(input logic ce, input logic ack, input logic rst);
        @(negedge clk);
        reset       = rst;
        bus.ce5     = ce;
        bus.irq_ack = ack;
        #1;
    endtask

    // Advance the reference across the coming edge using the inputs just driven.
    task automatic commit();
        if (reset) begin
            mh   = 0;
            mv   = 0;
            mirq = 1'b0;
        end else begin
            if (bus.ce5 && mh == 0 && (mv % 64) == 0) mirq = 1'b1;
            else if (bus.irq_ack) mirq = 1'b0;
            if (bus.ce5) begin
                if (mh == 319) begin
                    mh = 0;
                    mv = (mv == 255) ? 0 : mv + 1;
                end else begin
                    mh = mh + 1;
                end
            end
        end
    endtask

    function automatic logic [22:0] exp_vec();
        logic [8:0] h;
        logic [7:0] v;
        logic hb, vb, hs, vs, fs;
        h  = mh[8:0];
        v  = mv[7:0];
        hb = (mh >= 256);
        vb = (mv >= 232);
        hs = !(mh >= 272 && mh < 304);
        vs = !(mv >= 240 && mv < 244);
        fs = bus.ce5 && !reset && mh == 0 && mv == 0;
        return {h, v, hb, vb, hs, vs, fs, mirq};
    endfunction

    task automatic test_reset();
        logic [22:0] idle;
        idle = {9'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        drive(1'b1, 1'b1, 1'b1);
        commit();
        repeat (2) begin
            drive(1'b1, 1'b1, 1'b1);
            vectors++;
            if (obs !== idle) begin
                miscompares++;
                $display("FAIL reset_hold: got %h required %h", obs, idle);
            end
            commit();
        end
        drive(1'b0, 1'b0, 1'b0);
        vectors++;
        if (obs !== idle) begin
            miscompares++;
            $display("FAIL after_reset: got %h required %h", obs, idle);
        end
        commit();
    endtask

    // ce5 every other clk: 640 clk per line.
    task automatic test_line_ce_toggle();
        for (int i = 0; i < 644; i++) begin
            drive((i % 2) == 0, 1'b0, 1'b0);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL line_toggle i=%0d: got %h required %h", i, obs, exp_vec());
            end
            if (i == 0) begin
                vectors++;
                if (bus.frame_start !== 1'b1) begin
                    miscompares++;
                    $display("FAIL first_frame_start: got %b required 1", bus.frame_start);
                end
            end
            if (i == 639) begin
                vectors++;
                if (bus.hcount !== 9'd0 || bus.vcount !== 8'd1) begin
                    miscompares++;
                    $display("FAIL line_wrap: got h=%0d v=%0d required h=0 v=1",
                             bus.hcount, bus.vcount);
                end
            end
            if (i == 640) begin
                vectors++;
                if (bus.irq !== 1'b1) begin
                    miscompares++;
                    $display("FAIL irq_line0: got %b required 1", bus.irq);
                end
            end
            commit();
        end
    endtask

    // Ack at line 10, re-set at line 64, then reset mid-hsync at line 100.
    task automatic test_irq_mid_reset();
        int guard;
        drive(1'b0, 1'b0, 1'b1);
        commit();
        guard = 0;
        while (!(mh == 280 && mv == 100) && guard < 40000) begin
            drive(1'b1, (mv == 10 && mh == 5), 1'b0);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL irq_run h=%0d v=%0d: got %h required %h", mh, mv, obs, exp_vec());
            end
            if ((mv == 10 && mh == 6) || (mv == 64 && mh == 0) || (mv == 64 && mh == 1)) begin
                vectors++;
                if (bus.irq !== (mv == 64 && mh == 1)) begin
                    miscompares++;
                    $display("FAIL irq_ack_line10 h=%0d v=%0d: got %b required %b",
                             mh, mv, bus.irq, (mv == 64 && mh == 1));
                end
            end
            commit();
            guard++;
        end
        drive(1'b1, 1'b0, 1'b1);
        vectors++;
        if (bus.hcount !== 9'd280 || bus.vcount !== 8'd100 || bus.hsync_n !== 1'b0 ||
            bus.frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_reset: got h=%0d v=%0d hs_n=%b fs=%b required 280 100 0 0",
                     bus.hcount, bus.vcount, bus.hsync_n, bus.frame_start);
        end
        commit();
        drive(1'b1, 1'b0, 1'b0);
        vectors++;
        if (obs !== {9'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset: got %h required %h", obs,
                     {9'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
        end
        commit();
    endtask

    // One full frame with ce5 held high, acks at lines 128 (set cycle), 150, 160.
    task automatic test_frame();
        int fs_count;
        int fs_first;
        int fs_last;
        logic [1:0] hv;
        logic       chk;
        drive(1'b0, 1'b0, 1'b1);
        commit();
        fs_count = 0;
        fs_first = -1;
        fs_last  = -1;
        for (int n = 0; n <= 81920; n++) begin
            drive(1'b1, (mh == 0) && (mv == 128 || mv == 150 || mv == 160), 1'b0);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL frame h=%0d v=%0d: got %h required %h", mh, mv, obs, exp_vec());
            end
            if (bus.frame_start === 1'b1) begin
                fs_count++;
                if (fs_first < 0) fs_first = n;
                fs_last = n;
            end
            chk = 1'b1;
            hv  = 2'b00;
            if (mv == 1) begin
                case (mh)
                    255:     hv = 2'b01;
                    256:     hv = 2'b11;
                    271:     hv = 2'b11;
                    272:     hv = 2'b10;
                    303:     hv = 2'b10;
                    304:     hv = 2'b11;
                    default: chk = 1'b0;
                endcase
                if (chk) begin
                    vectors++;
                    if ({bus.hblank, bus.hsync_n} !== hv) begin
                        miscompares++;
                        $display("FAIL hdecode h=%0d: got %b required %b", mh,
                                 {bus.hblank, bus.hsync_n}, hv);
                    end
                end
            end
            chk = 1'b1;
            if (mh == 0) begin
                case (mv)
                    231:     hv = 2'b01;
                    232:     hv = 2'b11;
                    239:     hv = 2'b11;
                    240:     hv = 2'b10;
                    243:     hv = 2'b10;
                    244:     hv = 2'b11;
                    default: chk = 1'b0;
                endcase
                if (chk) begin
                    vectors++;
                    if ({bus.vblank, bus.vsync_n} !== hv) begin
                        miscompares++;
                        $display("FAIL vdecode v=%0d: got %b required %b", mv,
                                 {bus.vblank, bus.vsync_n}, hv);
                    end
                end
            end
            if (mh == 1 && (mv == 64 || mv == 128 || mv == 150 || mv == 160 || mv == 192)) begin
                vectors++;
                if (bus.irq !== (mv == 64 || mv == 128 || mv == 192)) begin
                    miscompares++;
                    $display("FAIL irq_frame v=%0d: got %b required %b", mv, bus.irq,
                             (mv == 64 || mv == 128 || mv == 192));
                end
            end
            commit();
        end
        vectors++;
        if (fs_count !== 2 || fs_first !== 0 || fs_last !== 81920) begin
            miscompares++;
            $display("FAIL frame_period: got count=%0d first=%0d last=%0d required 2 0 81920",
                     fs_count, fs_first, fs_last);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mh          = 0;
        mv          = 0;
        mirq        = 1'b0;
        bus.ce5     = 1'b0;
        bus.irq_ack = 1'b0;
        test_reset();
        test_line_ce_toggle();
        test_irq_mid_reset();
        test_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
